// File: rtl/cp0_exc_ctrl_if.sv
// MEM-stage exception bus between the pipeline and the CP0 exception controller.
// The pipeline side is the master; the controller is the slave.
interface cp0_exc_ctrl_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  valid_i;
  logic [7:0]            exc_vec_i;
  logic [31:0]           pc_i;
  logic [31:0]           badaddr_i;
  logic                  is_delay_slot_i;
  logic [NUM_HW_INT-1:0] hw_int_i;
  logic                  cp0_we_i;
  logic [4:0]            cp0_waddr_i;
  logic [31:0]           cp0_wdata_i;
  logic [4:0]            cp0_raddr_i;
  logic [31:0]           cp0_rdata_o;
  logic                  flush_o;
  logic                  redirect_o;
  logic [31:0]           redirect_pc_o;
  logic [4:0]            exc_code_o;
  logic                  timer_int_o;

  modport master (
    output valid_i, exc_vec_i, pc_i, badaddr_i, is_delay_slot_i, hw_int_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
    input  cp0_rdata_o, flush_o, redirect_o, redirect_pc_o, exc_code_o, timer_int_o
  );

  modport slave (
    input  valid_i, exc_vec_i, pc_i, badaddr_i, is_delay_slot_i, hw_int_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
    output cp0_rdata_o, flush_o, redirect_o, redirect_pc_o, exc_code_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Precise-exception controller at MEM: owns BadVAddr/Count/Compare/Status/Cause/EPC,
// prioritises exceptions and interrupts, and produces flush plus redirect PC.
module cp0_exc_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input logic           clk,
  input logic           rst,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam int          PW           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   epc_q, epc_d;
  logic [7:0]    im_q, im_d;
  logic          exl_q, exl_d;
  logic          ie_q, ie_d;
  logic          bd_q, bd_d;
  logic          ti_q, ti_d;
  logic [4:0]    exc_code_q, exc_code_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic [5:0]    ip_hw_q;
  logic [PW-1:0] presc_q, presc_d;

  // External lines zero-padded to the six hardware IP slots.
  logic [5:0] hw_ext;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_hw
      if (gi < NUM_HW_INT) begin : g_used
        assign hw_ext[gi] = bus.hw_int_i[gi];
      end else begin : g_tied
        assign hw_ext[gi] = 1'b0;
      end
    end
  endgenerate

  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_count   = bus.cp0_we_i && (bus.cp0_waddr_i == REG_COUNT);
  assign wr_compare = bus.cp0_we_i && (bus.cp0_waddr_i == REG_COMPARE);
  assign wr_status  = bus.cp0_we_i && (bus.cp0_waddr_i == REG_STATUS);
  assign wr_cause   = bus.cp0_we_i && (bus.cp0_waddr_i == REG_CAUSE);
  assign wr_epc     = bus.cp0_we_i && (bus.cp0_waddr_i == REG_EPC);

  // Effective values: the WB-stage MTC0 is bypassed into this cycle's decision.
  logic [7:0]  eff_im;
  logic        eff_exl, eff_ie;
  logic [1:0]  eff_ip_sw;
  logic [31:0] eff_epc;
  logic [7:0]  ip_full;
  logic        int_pend;

  assign eff_im    = wr_status ? bus.cp0_wdata_i[15:8] : im_q;
  assign eff_exl   = wr_status ? bus.cp0_wdata_i[1]    : exl_q;
  assign eff_ie    = wr_status ? bus.cp0_wdata_i[0]    : ie_q;
  assign eff_ip_sw = wr_cause  ? bus.cp0_wdata_i[9:8]  : ip_sw_q;
  assign eff_epc   = wr_epc    ? bus.cp0_wdata_i       : epc_q;
  assign ip_full   = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], eff_ip_sw};
  assign int_pend  = bus.valid_i && (|(ip_full & eff_im)) && !eff_exl && eff_ie;

  logic       exc_take, eret_take, bad_from_pc, bad_from_addr;
  logic [4:0] sel_code;

  always_comb begin
    exc_take      = 1'b0;
    eret_take     = 1'b0;
    bad_from_pc   = 1'b0;
    bad_from_addr = 1'b0;
    sel_code      = 5'd0;
    if (!rst && bus.valid_i) begin
      if (int_pend) begin
        exc_take = 1'b1;
      end else if (bus.exc_vec_i[0]) begin
        exc_take    = 1'b1;
        sel_code    = 5'd4;
        bad_from_pc = 1'b1;
      end else if (bus.exc_vec_i[1]) begin
        exc_take = 1'b1;
        sel_code = 5'd10;
      end else if (bus.exc_vec_i[2]) begin
        exc_take = 1'b1;
        sel_code = 5'd8;
      end else if (bus.exc_vec_i[3]) begin
        exc_take = 1'b1;
        sel_code = 5'd9;
      end else if (bus.exc_vec_i[4]) begin
        exc_take = 1'b1;
        sel_code = 5'd12;
      end else if (bus.exc_vec_i[5]) begin
        exc_take      = 1'b1;
        sel_code      = 5'd5;
        bad_from_addr = 1'b1;
      end else if (bus.exc_vec_i[6]) begin
        exc_take      = 1'b1;
        sel_code      = 5'd4;
        bad_from_addr = 1'b1;
      end else if (bus.exc_vec_i[7]) begin
        eret_take = 1'b1;
      end
    end
  end

  assign bus.flush_o       = exc_take | eret_take;
  assign bus.redirect_o    = exc_take | eret_take;
  assign bus.redirect_pc_o = exc_take ? EXC_VECTOR : (eret_take ? eff_epc : 32'd0);
  assign bus.exc_code_o    = exc_take ? sel_code : 5'd0;
  assign bus.timer_int_o   = !rst && ti_q;

  logic tick;
  assign tick = (presc_q == PW'(COUNT_DIV - 1));

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    count_d    = wr_count ? bus.cp0_wdata_i : (tick ? count_q + 32'd1 : count_q);
    compare_d  = wr_compare ? bus.cp0_wdata_i : compare_q;
    ti_d       = ti_q;
    // A Count write overrides the tick, so it also suppresses the match on that tick.
    if (wr_compare)
      ti_d = 1'b0;
    else if (tick && !wr_count && (count_q + 32'd1 == compare_q))
      ti_d = 1'b1;

    im_d       = eff_im;
    ie_d       = eff_ie;
    exl_d      = eff_exl;
    ip_sw_d    = eff_ip_sw;
    epc_d      = eff_epc;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    badvaddr_d = badvaddr_q;
    if (exc_take) begin
      exl_d      = 1'b1;
      exc_code_d = sel_code;
      // Nested exceptions keep the EPC/BD of the outermost one.
      if (!eff_exl) begin
        epc_d = bus.is_delay_slot_i ? bus.pc_i - 32'd4 : bus.pc_i;
        bd_d  = bus.is_delay_slot_i;
      end
      if (bad_from_pc)
        badvaddr_d = bus.pc_i;
      else if (bad_from_addr)
        badvaddr_d = bus.badaddr_i;
    end else if (eret_take) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      presc_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= hw_ext;
      presc_q    <= presc_d;
    end
  end

  always_comb begin
    bus.cp0_rdata_o = 32'd0;
    if (rst) begin
      if (bus.cp0_raddr_i == REG_STATUS)
        bus.cp0_rdata_o = STATUS_RST;
    end else begin
      case (bus.cp0_raddr_i)
        REG_BADVADDR: bus.cp0_rdata_o = badvaddr_q;
        REG_COUNT:    bus.cp0_rdata_o = count_q;
        REG_COMPARE:  bus.cp0_rdata_o = compare_q;
        REG_STATUS:   bus.cp0_rdata_o = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
        REG_CAUSE:    bus.cp0_rdata_o = {bd_q, ti_q, 14'd0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                                         ip_sw_q, 1'b0, exc_code_q, 2'b00};
        REG_EPC:      bus.cp0_rdata_o = epc_q;
        default:      bus.cp0_rdata_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then random traffic, every cycle
// compared against a word-level model of the CP0 registers.
module tb_cp0_exc_ctrl;
  localparam int          NHW    = 6;
  localparam int          DIV    = 2;
  localparam logic [31:0] VECTOR = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  cp0_exc_ctrl_if #(.NUM_HW_INT(NHW)) bus ();

  cp0_exc_ctrl #(.NUM_HW_INT(NHW), .EXC_VECTOR(VECTOR), .COUNT_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: architectural words, not RTL fields.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  logic        m_ti;
  logic [5:0]  m_hw;
  int          m_cyc;

  logic        e_take, e_eret;
  logic [4:0]  e_code;
  int          e_src;
  logic [31:0] e_status, e_epc;
  logic [1:0]  e_sw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status  = 32'h0040_0000;
    m_cause   = 32'd0;
    m_epc     = 32'd0;
    m_badv    = 32'd0;
    m_count   = 32'd0;
    m_compare = 32'd0;
    m_ti      = 1'b0;
    m_hw      = 6'd0;
    m_cyc     = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] ipw;
    ipw = {16'd0, m_hw[5] | m_ti, m_hw[4:0], 10'd0};
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause | ipw | (m_ti ? 32'h4000_0000 : 32'd0);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic predict();
    int         codes[7] = '{4, 10, 8, 9, 12, 5, 4};
    logic [7:0] ip;
    logic       we;
    we       = bus.cp0_we_i;
    e_status = (we && bus.cp0_waddr_i == 5'd12) ? ((bus.cp0_wdata_i & 32'h0000_FF03) | 32'h0040_0000) : m_status;
    e_sw     = (we && bus.cp0_waddr_i == 5'd13) ? bus.cp0_wdata_i[9:8] : m_cause[9:8];
    e_epc    = (we && bus.cp0_waddr_i == 5'd14) ? bus.cp0_wdata_i : m_epc;
    ip       = {m_hw[5] | m_ti, m_hw[4:0], e_sw};
    e_take = 1'b0;
    e_eret = 1'b0;
    e_code = 5'd0;
    e_src  = -1;
    if (!rst && bus.valid_i) begin
      if ((ip & e_status[15:8]) != 8'd0 && !e_status[1] && e_status[0]) e_take = 1'b1;
      for (int i = 0; i < 7; i++)
        if (!e_take && bus.exc_vec_i[i]) begin
          e_take = 1'b1;
          e_code = 5'(codes[i]);
          e_src  = i;
        end
      if (!e_take && bus.exc_vec_i[7]) e_eret = 1'b1;
    end
  endtask

  task automatic model_edge();
    logic tick, wc, wcmp;
    if (rst) begin
      model_reset();
    end else begin
      tick = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      wc   = bus.cp0_we_i && bus.cp0_waddr_i == 5'd9;
      wcmp = bus.cp0_we_i && bus.cp0_waddr_i == 5'd11;
      if (wcmp) m_ti = 1'b0;
      else if (tick && !wc && m_count + 32'd1 == m_compare) m_ti = 1'b1;
      if (wc) m_count = bus.cp0_wdata_i;
      else if (tick) m_count = m_count + 32'd1;
      if (wcmp) m_compare = bus.cp0_wdata_i;
      m_status     = e_status;
      m_cause[9:8] = e_sw;
      m_epc        = e_epc;
      if (e_take) begin
        if (!e_status[1]) begin
          m_epc       = bus.is_delay_slot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          m_cause[31] = bus.is_delay_slot_i;
        end
        m_status[1]  = 1'b1;
        m_cause[6:2] = e_code;
        if (e_src == 0) m_badv = bus.pc_i;
        else if (e_src == 5 || e_src == 6) m_badv = bus.badaddr_i;
      end
      if (e_eret) m_status[1] = 1'b0;
      m_hw = bus.hw_int_i;
    end
  endtask

  // One clock: compare all outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [31:0] exp_rd;
    @(negedge clk);
    predict();
    exp_rd = rst ? ((bus.cp0_raddr_i == 5'd12) ? 32'h0040_0000 : 32'd0) : m_read(bus.cp0_raddr_i);
    chk("flush", {31'd0, bus.flush_o}, {31'd0, e_take | e_eret});
    chk("redirect", {31'd0, bus.redirect_o}, {31'd0, e_take | e_eret});
    chk("redirect_pc", bus.redirect_pc_o, e_take ? VECTOR : (e_eret ? e_epc : 32'd0));
    chk("exc_code", {27'd0, bus.exc_code_o}, {27'd0, e_code});
    chk("timer_int", {31'd0, bus.timer_int_o}, {31'd0, !rst && m_ti});
    chk("rdata", bus.cp0_rdata_o, exp_rd);
    $display("cyc rst=%0d v=%0d ev=%h we=%0d wa=%0d ra=%0d rd=%h flush=%0d code=%0d ti=%0d",
             rst, bus.valid_i, bus.exc_vec_i, bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_raddr_i,
             bus.cp0_rdata_o, bus.flush_o, bus.exc_code_o, bus.timer_int_o);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.valid_i         = 1'b0;
    bus.exc_vec_i       = 8'd0;
    bus.pc_i            = 32'd0;
    bus.badaddr_i       = 32'd0;
    bus.is_delay_slot_i = 1'b0;
    bus.cp0_we_i        = 1'b0;
    bus.cp0_waddr_i     = 5'd0;
    bus.cp0_wdata_i     = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we_i    = 1'b1;
    bus.cp0_waddr_i = a;
    bus.cp0_wdata_i = d;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.cp0_raddr_i = a;
    #1;
    d = bus.cp0_rdata_o;
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    int          wregs[7] = '{8, 9, 11, 12, 13, 14, 3};

    rst = 1'b1;
    idle();
    bus.hw_int_i    = '0;
    bus.cp0_raddr_i = 5'd12;
    model_reset();
    @(posedge clk);
    #1;

    // Reset values, Count running, and a mid-count reset pulse.
    step();
    step();
    chk("rst_status", bus.cp0_rdata_o, 32'h0040_0000);
    rst = 1'b0;
    bus.cp0_raddr_i = 5'd9;
    repeat (7) step();
    chk("count_running", bus.cp0_rdata_o, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("count_after_rst", bus.cp0_rdata_o, 32'd0);

    // Timer: Compare=10, IM7+IE, TI rises on reset-relative edge 20.
    n = 0;
    mtc0(5'd11, 32'd10);
    step(); n++;
    mtc0(5'd12, 32'h0000_8001);
    step(); n++;
    idle();
    while (!bus.timer_int_o && n < 40) begin
      step(); n++;
    end
    chk("ti_edge", n, 20);
    bus.valid_i = 1'b1;
    bus.pc_i    = 32'h8000_5000;
    #1;
    chk("ti_int_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("ti_int_code", {27'd0, bus.exc_code_o}, 32'd0);
    step();
    idle();
    mtc0(5'd11, 32'd1000);
    step();
    idle();
    chk("ti_cleared", {31'd0, bus.timer_int_o}, 32'd0);

    // Ov in a delay slot, plus a bubble carrying flags.
    mtc0(5'd12, 32'd0);
    step();
    idle();
    bus.exc_vec_i = 8'h10;
    #1;
    chk("bubble_flush", {31'd0, bus.flush_o}, 32'd0);
    bus.valid_i         = 1'b1;
    bus.pc_i            = 32'h8000_1000;
    bus.is_delay_slot_i = 1'b1;
    #1;
    chk("ov_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("ov_vector", bus.redirect_pc_o, 32'hBFC0_0380);
    chk("ov_code", {27'd0, bus.exc_code_o}, 32'd12);
    step();
    idle();
    rd(5'd14, d); chk("ov_epc", d, 32'h8000_0FFC);
    rd(5'd13, d); chk("ov_bd", {31'd0, d[31]}, 32'd1);
    rd(5'd12, d); chk("ov_exl", {31'd0, d[1]}, 32'd1);

    // RI beats Ov; then a nested Ov keeps EPC.
    mtc0(5'd12, 32'd0);
    step();
    idle();
    bus.valid_i   = 1'b1;
    bus.exc_vec_i = 8'h12;
    bus.pc_i      = 32'h8000_2000;
    #1;
    chk("ri_over_ov", {27'd0, bus.exc_code_o}, 32'd10);
    step();
    bus.exc_vec_i = 8'h10;
    bus.pc_i      = 32'h8000_3000;
    #1;
    chk("nested_code", {27'd0, bus.exc_code_o}, 32'd12);
    step();
    idle();
    rd(5'd14, d); chk("nested_epc", d, 32'h8000_2000);
    rd(5'd13, d); chk("nested_exccode", {27'd0, d[6:2]}, 32'd12);

    // Eret with a same-cycle EPC write uses the bypassed value.
    bus.valid_i   = 1'b1;
    bus.exc_vec_i = 8'h80;
    mtc0(5'd14, 32'h8000_4000);
    #1;
    chk("eret_flush", {31'd0, bus.flush_o}, 32'd1);
    chk("eret_target", bus.redirect_pc_o, 32'h8000_4000);
    step();
    idle();
    rd(5'd12, d); chk("eret_exl", {31'd0, d[1]}, 32'd0);

    // hw_int[0] with IM2/IE, masked by a same-cycle IE=0 write; then unmasked.
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int_i = 6'd1;
    step();
    idle();
    bus.valid_i = 1'b1;
    mtc0(5'd12, 32'h0000_0400);
    #1;
    chk("bypass_ie_off", {31'd0, bus.flush_o}, 32'd0);
    step();
    idle();
    mtc0(5'd12, 32'h0000_0401);
    step();
    idle();
    bus.valid_i = 1'b1;
    #1;
    chk("hw_int_taken", {31'd0, bus.flush_o}, 32'd1);
    step();
    idle();
    bus.hw_int_i = '0;

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rst                 = ($urandom_range(0, 199) == 0);
      bus.valid_i         = 1'($urandom_range(0, 1));
      for (int b = 0; b < 8; b++) bus.exc_vec_i[b] = ($urandom_range(0, 9) == 0);
      bus.pc_i            = $urandom & 32'hFFFF_FFFC;
      bus.badaddr_i       = $urandom;
      bus.is_delay_slot_i = 1'($urandom_range(0, 1));
      bus.hw_int_i        = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      bus.cp0_we_i        = ($urandom_range(0, 3) == 0);
      bus.cp0_waddr_i     = 5'(wregs[$urandom_range(0, 6)]);
      bus.cp0_wdata_i     = (bus.cp0_waddr_i == 5'd11 || bus.cp0_waddr_i == 5'd9) ?
                            32'($urandom_range(0, 40)) : $urandom;
      bus.cp0_raddr_i     = 5'(wregs[$urandom_range(0, 6)]);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Next-generation precise-exception controller for the MIPS pipeline, located at the MEM stage.
- Owns the CP0 exception register file: BadVAddr, Count, Compare, Status, Cause and EPC.
- Provides a parametrised hardware-interrupt width, an internal Count/Compare timer, exception prioritisation, pipeline flush and redirect-PC generation.
- Executes MTC0 writes from WB and MFC0 reads, with same-cycle bypass of a WB write into the exception decision.

Parameters:
NUM_HW_INT, 6, number of external interrupt lines (1..6); they map to Cause.IP[2+NUM_HW_INT-1:2].
EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt.
COUNT_DIV, 2, number of clock cycles per Count increment (must be ≥1).

Ports:
clk  in  1  clock
rst  in  1  reset
valid_i  in  1  MEM-stage instruction valid (not a bubble or a flushed slot)
exc_vec_i  in  8  exception flags: [0] AdEL-IF, [1] RI, [2] Sys, [3] Bp, [4] Ov, [5] AdES, [6] AdEL-MEM, [7] Eret
pc_i  in  32  PC of the MEM-stage instruction
badaddr_i  in  32  data address for AdES/AdEL-MEM
is_delay_slot_i  in  1  MEM-stage instruction is in a branch delay slot
hw_int_i  in  NUM_HW_INT  level-sensitive external interrupts
cp0_we_i  in  1  MTC0 write enable (WB stage)
cp0_waddr_i  in  5  MTC0 register number
cp0_wdata_i  in  32  MTC0 write data
cp0_raddr_i  in  5  MFC0 register number
cp0_rdata_o  out  32  MFC0 read data (combinational)
flush_o  out  1  flush IF/ID, ID/EXE, EXE/MEM and MEM/WB; also kills the MEM-stage register write
redirect_o  out  1  fetch redirect valid
redirect_pc_o  out  32  fetch redirect target
exc_code_o  out  5  ExcCode of the exception taken this cycle
timer_int_o  out  1  Cause.TI

Behaviour:
- Reset is rst, synchronous, active-high.
- Register reset values:
  - Status = 32'h0040_0000 (BEV=1)
  - Cause, EPC, BadVAddr, Count and Compare = 0
- Output values while rst=1: all outputs 0, except cp0_rdata_o, which returns the reset register values.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. BEV reads 1; all other bits read 0.
  - Cause: IP[1:0] only.
  - EPC, BadVAddr (hardware-written only), Count, Compare: full 32 bits.
- Effective values: eff_Status, eff_Cause and eff_EPC equal the register value with any same-cycle MTC0 write applied (WB bypass). All exception decisions use the effective values.
- Cause.IP[7:2]: sampled every cycle.
  - IP[2+i] = hw_int_i[i] for i < NUM_HW_INT.
  - IP[7] = hw_int_i[5] | TI. Unused bits read 0.
- Timer:
  - A modulo-COUNT_DIV prescaler increments Count on each tick.
  - TI is set on the tick where Count+1 == Compare.
  - TI is cleared by an MTC0 write to Compare.
  - On a same-cycle MTC0 write to Count, the write wins over the tick.
- Interrupt pending (int_pend) when all hold:
  - (eff_Cause.IP & eff_Status.IM) != 0
  - eff_Status.EXL == 0
  - eff_Status.IE == 1
  - valid_i == 1
- Priority (first match wins, only when valid_i=1):

  | Rank | Condition | ExcCode |
  |---|---|---|
  | 1 | Int | 0 |
  | 2 | AdEL-IF | 4 |
  | 3 | RI | 10 |
  | 4 | Sys | 8 |
  | 5 | Bp | 9 |
  | 6 | Ov | 12 |
  | 7 | AdES | 5 |
  | 8 | AdEL-MEM | 4 |
  | 9 | Eret | — |

- Taken exception or interrupt (same cycle, combinational outputs):
  - flush_o = 1, redirect_o = 1, redirect_pc_o = EXC_VECTOR, exc_code_o = code.
- Taken exception or interrupt (register updates at the next edge):
  - Cause.ExcCode is written.
  - Status.EXL is set to 1.
  - If the old EXL was 0: EPC = is_delay_slot_i ? pc_i-4 : pc_i, and Cause.BD = is_delay_slot_i.
  - If the old EXL was 1: EPC and BD are unchanged.
  - BadVAddr = pc_i for AdEL-IF; BadVAddr = badaddr_i for AdES or AdEL-MEM.
- Eret:
  - Same cycle: flush_o = 1, redirect_o = 1, redirect_pc_o = eff_EPC, exc_code_o = 0.
  - Next edge: EXL is cleared.
- Simultaneous MTC0 and exception in the same cycle:
  - The exception update wins on EXL, EPC, BD, ExcCode and BadVAddr.
  - The MTC0 value is applied to all other fields.
- Outputs when valid_i=0: no exception or flush, even if flags are set.
- No internal stall: each MEM instruction is evaluated exactly once, in its valid cycle.

Test Plan:
1. Reset, then read Status/Count -> 32'h0040_0000 / 0. Pulse rst mid-count -> Count returns to 0 on the next edge.
2. Ov flag, pc_i=32'h8000_1000, delay slot=1 -> same cycle: flush_o=1, redirect_pc_o=32'hBFC0_0380, exc_code_o=12. Next cycle: EPC=32'h8000_0FFC, BD=1, EXL=1.
3. RI and Ov set together -> exc_code_o=10. Repeat with EXL=1 -> EPC unchanged and ExcCode=12.
4. Same cycle: MTC0 EPC=32'h8000_2000 plus Eret -> redirect_pc_o=32'h8000_2000. Next cycle: EXL=0.
5. Compare=10, COUNT_DIV=2, IM[7]=1, IE=1 -> TI rises on the tick Count→10 (cycle 20 after reset) and the next valid instruction takes Int (code 0). A Compare write clears TI.
6. hw_int_i[0]=1 with IM[2]=1, IE=1, and a same-cycle MTC0 writing IE=0 -> no interrupt taken (bypass verified).
